wr_timeout_checker: RTL and testbench
=====================================

// Module: wr_timeout_checker
// PURPOSE
// - Per-slot write-timeout detector. Sits directly downstream of the write-slot latency counters.
// - Consumes one slot's registered linked data (free flag, write_state, six phase counters).
// - Compares each counter against a per-phase budget and latches the first violation.
// - Reports the violation once over a valid/ready handshake and holds a sticky timeout flag until the slot is freed.
// PARAMETERS
// - CntWidth       2      width of every phase counter and budget
// - linked_data_t  logic  slot record type (.free, .id, .write_state, .counters.cnt_*)
// - id_t           logic  AXI write ID type carried in the report
// PORTS
// - clk_i            in   1            clock
// - rst_ni           in   1            asynchronous reset, active low
// - linked_data_i    in   linked_data_t  slot record from the counter stage (registered)
// - budgets_i        in   wr_budgets_t   six CntWidth budgets, one per phase; 0 = phase check disabled
// - report_ready_i   in   1            downstream error unit accepts report
// - report_valid_o   out  1            timeout report pending
// - report_id_o      out  id_t         AXI ID of the timed-out slot
// - report_phase_o   out  wr_phase_e   phase that exceeded its budget
// - report_cnt_o     out  CntWidth     counter value at detection
// - timeout_o        out  1            sticky: slot has timed out, cleared when slot frees
// BEHAVIOUR
// - Reset values: report_valid_o=0, report_id_o=0, report_phase_o=PH_NONE, report_cnt_o=0, timeout_o=0, FSM=IDLE.
// - Phase index order, also the priority order (lowest wins on simultaneous crossings):
//   - 0 AW_AWREADY
//   - 1 AW_WFIRST
//   - 2 W_WREADY_FIRST
//   - 3 WFIRST_WLAST
//   - 4 WLAST_BVALID
//   - 5 BVALID_BREADY
// - Crossing: budget!=0 && cnt >= budget, unsigned CntWidth compare, evaluated combinationally on linked_data_i.
//   - No extension or wrap handling: the counters wrap upstream, so only the first crossing is captured.
// - FSM:
//   - IDLE:
//     - free=0 -> ARMED.
//   - ARMED:
//     - free=1 -> IDLE, no report.
//     - Any crossing, with free=0 -> REPORT. In the same edge:
//       - Latch id, phase and cnt.
//       - Set timeout_o=1 and report_valid_o=1.
//     - Latency: report_valid_o rises 1 cycle after the crossing is visible on linked_data_i.
//   - REPORT:
//     - report_valid_o held high; id/phase/cnt held stable until report_ready_i.
//     - Handshake -> drop valid, go to HOLD.
//     - Valid is never withdrawn before the handshake, even if the slot frees.
//     - If free=1 coincides with the handshake -> IDLE directly, clear timeout_o.
//   - HOLD:
//     - timeout_o stays 1; further crossings are ignored (one report per occupancy).
//     - free=1 -> IDLE, clear timeout_o and report_phase_o -> PH_NONE.
// - free=1 and a crossing on the same cycle in ARMED: free wins, no report.
// - Slot freed while in REPORT without a handshake:
//   - Stay in REPORT until the handshake, then -> IDLE.
//   - timeout_o clears on exit.
// - Slot reallocated (free 1->0) while in REPORT/HOLD: impossible by protocol; the checker does not re-arm until IDLE is reached.
// - Budgets are sampled every cycle. A budget change takes effect on the next compare; latched report fields are unaffected.
// - Async reset mid-report drops report_valid_o immediately; no handshake is required.
// STRUCTURE
// - slv_pkg gains:
//   - wr_phase_e: 3-bit enum, PH_AW_AWREADY..PH_BVALID_BREADY, PH_NONE=7.
//   - wr_budgets_t: packed struct of six CntWidth fields, named as the counters.
//   - localparam NumWrPhases=6.
// - Sub-module wr_phase_cmp: pure combinational. counters + budgets -> hit, phase, cnt (priority encode). Instantiated once.
// - Top: 4-state FSM plus report registers. The checker sits one per slot, alongside the counter stage.
// TESTING
// - CntWidth=4, budgets all 5; hold AW counter at 4, then 5 -> report_valid_o=1 one cycle after 5, phase=AW_AWREADY, cnt=5, timeout_o=1.
// - Counters 1 and 4 both reach budget 3 on the same cycle -> phase=AW_WFIRST, a single report.
// - report_ready_i low for 10 cycles, counters keep rising -> valid stays high, id/phase/cnt unchanged. Ready=1 -> valid=0 the next cycle, HOLD, no second report.
// - Budget 0 on every phase, counters run to 15 and wrap -> no report, timeout_o=0 throughout.
// - free goes 1 on the crossing cycle -> no report. Separately, free=1 during REPORT -> valid held until ready, then timeout_o=0, IDLE.
// - rst_ni low mid-REPORT -> all outputs return to reset values asynchronously. New occupancy after reset reports normally.

Source files
------------

// File: rtl/wr_timeout_checker_pkg.sv
// Shared types for the per-slot write-timeout checker: phase encoding,
// budget/counter records and the default slot record.
package wr_timeout_checker_pkg;

  localparam int unsigned NumWrPhases = 6;
  localparam int unsigned DefCntWidth = 2;
  localparam int unsigned DefIdWidth  = 4;

  // Index order doubles as priority order: lowest index wins.
  typedef enum logic [2:0] {
    PH_AW_AWREADY     = 3'd0,
    PH_AW_WFIRST      = 3'd1,
    PH_W_WREADY_FIRST = 3'd2,
    PH_WFIRST_WLAST   = 3'd3,
    PH_WLAST_BVALID   = 3'd4,
    PH_BVALID_BREADY  = 3'd5,
    PH_NONE           = 3'd7
  } wr_phase_e;

  typedef struct packed {
    logic [DefCntWidth-1:0] cnt_aw_awready;
    logic [DefCntWidth-1:0] cnt_aw_wfirst;
    logic [DefCntWidth-1:0] cnt_w_wready_first;
    logic [DefCntWidth-1:0] cnt_wfirst_wlast;
    logic [DefCntWidth-1:0] cnt_wlast_bvalid;
    logic [DefCntWidth-1:0] cnt_bvalid_bready;
  } wr_counters_t;

  typedef struct packed {
    logic [DefCntWidth-1:0] cnt_aw_awready;
    logic [DefCntWidth-1:0] cnt_aw_wfirst;
    logic [DefCntWidth-1:0] cnt_w_wready_first;
    logic [DefCntWidth-1:0] cnt_wfirst_wlast;
    logic [DefCntWidth-1:0] cnt_wlast_bvalid;
    logic [DefCntWidth-1:0] cnt_bvalid_bready;
  } wr_budgets_t;

  typedef struct packed {
    logic                  free;
    logic [DefIdWidth-1:0] id;
    logic [2:0]            write_state;
    wr_counters_t          counters;
  } wr_linked_data_t;

  // Maps a priority-encoder index to its phase; out-of-range yields PH_NONE.
  function automatic wr_phase_e phase_of(input logic [2:0] idx);
    wr_phase_e p;
    p = PH_NONE;
    if (idx < 3'(NumWrPhases)) p = wr_phase_e'(idx);
    return p;
  endfunction

endpackage

// File: rtl/wr_timeout_checker_phase_cmp.sv
// Combinational budget comparison across all write phases with a fixed
// priority encode of the first crossing phase.
module wr_phase_cmp
  import wr_timeout_checker_pkg::*;
#(
  parameter int unsigned CntWidth = DefCntWidth
) (
  input  logic [NumWrPhases-1:0][CntWidth-1:0] cnts,
  input  logic [NumWrPhases-1:0][CntWidth-1:0] budgets,
  output logic                                 hit,
  output wr_phase_e                            phase,
  output logic [CntWidth-1:0]                  cnt
);

  logic [NumWrPhases-1:0] crossing;
  logic [2:0]             idx;

  // A zero budget disables that phase's check entirely.
  for (genvar g = 0; g < NumWrPhases; g++) begin : g_cross
    assign crossing[g] = (budgets[g] != '0) && (cnts[g] >= budgets[g]);
  end

  always_comb begin
    idx = 3'd7;
    casez (crossing)
      6'b?????1: idx = 3'd0;
      6'b????10: idx = 3'd1;
      6'b???100: idx = 3'd2;
      6'b??1000: idx = 3'd3;
      6'b?10000: idx = 3'd4;
      6'b100000: idx = 3'd5;
      default:   idx = 3'd7;
    endcase
  end

  always_comb begin
    hit   = |crossing;
    phase = phase_of(idx);
    cnt   = '0;
    if (hit) cnt = cnts[idx];
  end

endmodule

// File: rtl/wr_timeout_checker.sv
// Per-slot write-timeout checker: latches the first phase-budget violation
// of an occupancy, reports it once over valid/ready, keeps a sticky flag.
module wr_timeout_checker
  import wr_timeout_checker_pkg::*;
#(
  parameter int unsigned CntWidth      = DefCntWidth,
  parameter type         linked_data_t = wr_linked_data_t,
  parameter type         id_t          = logic [DefIdWidth-1:0],
  parameter type         budgets_t     = wr_budgets_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  linked_data_t        linked_data_i,
  input  budgets_t            budgets_i,
  input  logic                report_ready_i,
  output logic                report_valid_o,
  output id_t                 report_id_o,
  output wr_phase_e           report_phase_o,
  output logic [CntWidth-1:0] report_cnt_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e                              state;
  logic                                valid;
  id_t                                 id;
  wr_phase_e                           phase;
  logic [CntWidth-1:0]                 cnt;
  logic                                timeout;
  logic                                freed;
  logic [NumWrPhases-1:0][CntWidth-1:0] cnts;
  logic [NumWrPhases-1:0][CntWidth-1:0] budgets;
  logic                                hit;
  wr_phase_e                           hit_phase;
  logic [CntWidth-1:0]                 hit_cnt;
  logic                                free;
  logic                                unused_write_state;

  assign free               = linked_data_i.free;
  assign unused_write_state = ^linked_data_i.write_state;

  assign cnts[0] = linked_data_i.counters.cnt_aw_awready;
  assign cnts[1] = linked_data_i.counters.cnt_aw_wfirst;
  assign cnts[2] = linked_data_i.counters.cnt_w_wready_first;
  assign cnts[3] = linked_data_i.counters.cnt_wfirst_wlast;
  assign cnts[4] = linked_data_i.counters.cnt_wlast_bvalid;
  assign cnts[5] = linked_data_i.counters.cnt_bvalid_bready;

  assign budgets[0] = budgets_i.cnt_aw_awready;
  assign budgets[1] = budgets_i.cnt_aw_wfirst;
  assign budgets[2] = budgets_i.cnt_w_wready_first;
  assign budgets[3] = budgets_i.cnt_wfirst_wlast;
  assign budgets[4] = budgets_i.cnt_wlast_bvalid;
  assign budgets[5] = budgets_i.cnt_bvalid_bready;

  wr_phase_cmp #(
    .CntWidth(CntWidth)
  ) u_cmp (
    .cnts   (cnts),
    .budgets(budgets),
    .hit    (hit),
    .phase  (hit_phase),
    .cnt    (hit_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      valid   <= 1'b0;
      id      <= '0;
      phase   <= PH_NONE;
      cnt     <= '0;
      timeout <= 1'b0;
      freed   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          freed <= 1'b0;
          if (!free) state <= ARMED;
        end
        ARMED: begin
          if (free) begin
            state <= IDLE;
          end else if (hit) begin
            state   <= REPORT;
            id      <= linked_data_i.id;
            phase   <= hit_phase;
            cnt     <= hit_cnt;
            valid   <= 1'b1;
            timeout <= 1'b1;
          end
        end
        REPORT: begin
          // A free seen before the handshake is remembered so the exit
          // after the handshake goes straight to IDLE.
          if (report_ready_i) begin
            valid <= 1'b0;
            if (free || freed) begin
              state   <= IDLE;
              timeout <= 1'b0;
              phase   <= PH_NONE;
              freed   <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else if (free) begin
            freed <= 1'b1;
          end
        end
        HOLD: begin
          if (free) begin
            state   <= IDLE;
            timeout <= 1'b0;
            phase   <= PH_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign report_valid_o = valid;
  assign report_id_o    = id;
  assign report_phase_o = phase;
  assign report_cnt_o   = cnt;
  assign timeout_o      = timeout;

endmodule

// File: tb/tb_wr_timeout_checker.sv
// Scoreboard bench for wr_timeout_checker with 4-bit counters.
module tb_wr_timeout_checker;
  import wr_timeout_checker_pkg::*;

  typedef struct packed {
    logic [3:0] cnt_aw_awready;
    logic [3:0] cnt_aw_wfirst;
    logic [3:0] cnt_w_wready_first;
    logic [3:0] cnt_wfirst_wlast;
    logic [3:0] cnt_wlast_bvalid;
    logic [3:0] cnt_bvalid_bready;
  } tb_cnt_t;

  typedef struct packed {
    logic       free;
    logic [3:0] id;
    logic [2:0] write_state;
    tb_cnt_t    counters;
  } tb_ld_t;

  typedef struct {
    logic [3:0] id;
    wr_phase_e  phase;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  tb_ld_t     ld;
  tb_cnt_t    bud;
  logic       ready;
  logic       valid;
  logic [3:0] rid;
  wr_phase_e  rphase;
  logic [3:0] rcnt;
  logic       timeout;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  wr_timeout_checker #(
    .CntWidth     (4),
    .linked_data_t(tb_ld_t),
    .id_t         (logic [3:0]),
    .budgets_t    (tb_cnt_t)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .linked_data_i (ld),
    .budgets_i     (bud),
    .report_ready_i(ready),
    .report_valid_o(valid),
    .report_id_o   (rid),
    .report_phase_o(rphase),
    .report_cnt_o  (rcnt),
    .timeout_o     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] id, input wr_phase_e ph, input logic [3:0] c);
    exp_t e;
    e.id    = id;
    e.phase = ph;
    e.cnt   = c;
    sb_q.push_back(e);
  endtask

  task automatic set_all_cnt(input logic [3:0] v);
    ld.counters = {6{v}};
  endtask

  task automatic set_all_bud(input logic [3:0] v);
    bud = {6{v}};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   32'(valid),   32'd0);
    chk({tag, "_id"},      32'(rid),     32'd0);
    chk({tag, "_phase"},   32'(rphase),  32'(PH_NONE));
    chk({tag, "_cnt"},     32'(rcnt),    32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // Monitor: a handshake completes on the next rising edge; check it here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid && ready) begin
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_report", 32'(rphase), 32'(PH_NONE));
        end else begin
          e = sb_q.pop_front();
          chk("mon_id",    32'(rid),    32'(e.id));
          chk("mon_phase", 32'(rphase), 32'(e.phase));
          chk("mon_cnt",   32'(rcnt),   32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    ld    = '0;
    ld.free = 1'b1;
    bud   = '0;
    #12;
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    step();

    // Single AW crossing, one-cycle latency.
    set_all_bud(4'd5);
    ld.id = 4'd3;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_aw_awready = 4'd4;
    step();
    chk("a_below_budget_valid", 32'(valid), 32'd0);
    ld.counters.cnt_aw_awready = 4'd5;
    push_exp(4'd3, PH_AW_AWREADY, 4'd5);
    step();
    chk("a_valid", 32'(valid), 32'd1);
    chk("a_timeout", 32'(timeout), 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("a_valid_after_hs", 32'(valid), 32'd0);
    chk("a_hold_timeout", 32'(timeout), 32'd1);
    ld.free = 1'b1;
    set_all_cnt(4'd0);
    step();
    chk("a_free_timeout", 32'(timeout), 32'd0);
    chk("a_free_phase", 32'(rphase), 32'(PH_NONE));

    // Simultaneous crossings on phases 1 and 4: lower index wins; stall ready.
    set_all_bud(4'd3);
    ld.id = 4'd5;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_aw_wfirst    = 4'd3;
    ld.counters.cnt_wlast_bvalid = 4'd3;
    push_exp(4'd5, PH_AW_WFIRST, 4'd3);
    step();
    chk("b_valid", 32'(valid), 32'd1);
    chk("b_phase", 32'(rphase), 32'(PH_AW_WFIRST));
    for (int i = 0; i < 10; i++) begin
      ld.counters.cnt_aw_awready = 4'(4 + i);
      ld.counters.cnt_aw_wfirst  = 4'(4 + i);
      step();
      chk("b_stall_valid", 32'(valid), 32'd1);
      chk("b_stall_id",    32'(rid),   32'd5);
      chk("b_stall_phase", 32'(rphase), 32'(PH_AW_WFIRST));
      chk("b_stall_cnt",   32'(rcnt),  32'd3);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("b_valid_after_hs", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_hold_valid",   32'(valid),   32'd0);
      chk("b_hold_timeout", 32'(timeout), 32'd1);
    end
    ld.free = 1'b1;
    set_all_cnt(4'd0);
    step();
    chk("b_free_timeout", 32'(timeout), 32'd0);

    // All budgets disabled: counters wrap, nothing reported.
    set_all_bud(4'd0);
    ld.id = 4'd7;
    ld.free = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      set_all_cnt(4'(i));
      step();
      chk("c_valid",   32'(valid),   32'd0);
      chk("c_timeout", 32'(timeout), 32'd0);
    end
    ld.free = 1'b1;
    set_all_cnt(4'd0);
    step();

    // Free on the crossing cycle wins.
    set_all_bud(4'd5);
    ld.id = 4'd8;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_bvalid_bready = 4'd5;
    ld.free = 1'b1;
    step();
    chk("d1_valid",   32'(valid),   32'd0);
    chk("d1_timeout", 32'(timeout), 32'd0);
    set_all_cnt(4'd0);
    step();

    // Free during REPORT: valid held until ready, then straight to IDLE.
    ld.id = 4'd9;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_w_wready_first = 4'd6;
    push_exp(4'd9, PH_W_WREADY_FIRST, 4'd6);
    step();
    chk("d2_valid", 32'(valid), 32'd1);
    ld.free = 1'b1;
    set_all_cnt(4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d2_freed_valid",   32'(valid),   32'd1);
      chk("d2_freed_timeout", 32'(timeout), 32'd1);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("d2_exit_valid",   32'(valid),   32'd0);
    chk("d2_exit_timeout", 32'(timeout), 32'd0);
    chk("d2_exit_phase",   32'(rphase),  32'(PH_NONE));
    step();

    // Asynchronous reset in the middle of a report.
    ld.id = 4'd2;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_wfirst_wlast = 4'd5;
    step();
    chk("e_pre_reset_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("e_async");
    step();
    rst_n = 1'b1;
    ld = '0;
    ld.free = 1'b1;
    step();

    // New occupancy after reset; budget changes before and after latching.
    set_all_bud(4'd5);
    bud.cnt_aw_awready = 4'd7;
    ld.id = 4'd6;
    ld.free = 1'b0;
    step();
    ld.counters.cnt_aw_awready = 4'd5;
    step();
    chk("f_budget7_valid", 32'(valid), 32'd0);
    bud.cnt_aw_awready = 4'd4;
    push_exp(4'd6, PH_AW_AWREADY, 4'd5);
    step();
    chk("f_valid", 32'(valid), 32'd1);
    bud.cnt_aw_awready = 4'd2;
    step();
    chk("f_cnt_after_budget_change", 32'(rcnt), 32'd5);
    ready = 1'b1;
    step();
    ready = 1'b0;
    ld.free = 1'b1;
    set_all_cnt(4'd0);
    step();
    chk("f_free_timeout", 32'(timeout), 32'd0);

    repeat (3) step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
